// File: rtl/multi_channel_accum_top.sv
// multi_channel_accum_top
//   NUM_CH independent accumulator channels. Each channel adds up DEPTH
//   unsigned samples, or fewer when flush closes it early, and then holds
//   the result. A round-robin arbiter moves held results, one per cycle,
//   into a single valid/ready output register.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   per-channel sample valid            [NUM_CH]
//   in_ready   per-channel sample ready (low in HOLD) [NUM_CH]
//   in_data    channel i at [i*WIDTH +: WIDTH], unsigned
//   flush      pulse that closes every channel with a nonzero count
//   out_valid  result valid
//   out_ready  result accept
//   out_data   sum of the closed group            [SUM_W]
//   out_ch     source channel index               [CH_W]
//   out_count  samples in the sum, 1..DEPTH       [CNT_W]
module multi_channel_accum_top #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  localparam int SUM_W = WIDTH + $clog2(DEPTH),
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic [CNT_W-1:0]        out_count
);

  logic [NUM_CH-1:0] hold_q, hold_d;
  logic [SUM_W-1:0]  sum_q [NUM_CH];
  logic [SUM_W-1:0]  sum_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [SUM_W-1:0]  acc_sum [NUM_CH];
  logic [CNT_W-1:0]  acc_cnt [NUM_CH];
  logic [NUM_CH-1:0] accept;

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   gnt_idx, cand;
  logic              found, load;

  logic              out_valid_q, out_valid_d;
  logic [SUM_W-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  assign in_ready  = ~hold_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_count = out_count_q;

  // Stage: channel accumulation (sample folded in before the close test,
  // so a flush on the same cycle as an accept includes that sample)
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i]  = in_valid[i] && !hold_q[i];
      acc_sum[i] = sum_q[i] + (accept[i] ? SUM_W'(in_data[i*WIDTH +: WIDTH]) : '0);
      acc_cnt[i] = cnt_q[i] + CNT_W'(accept[i]);
    end
  end

  // Stage: round-robin grant, searching from ptr+1 so the last winner
  // has lowest priority next time
  always_comb begin
    gnt_idx = ptr_q;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
      if (!found && hold_q[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
    load = (!out_valid_q || out_ready) && found;
  end

  // Stage: channel next state
  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_d[i] = sum_q[i];
      cnt_d[i] = cnt_q[i];
      if (hold_q[i]) begin
        if (load && gnt_idx == CH_W'(i)) begin
          hold_d[i] = 1'b0;
          sum_d[i]  = '0;
          cnt_d[i]  = '0;
        end
      end else begin
        sum_d[i] = acc_sum[i];
        cnt_d[i] = acc_cnt[i];
        if (acc_cnt[i] == CNT_W'(DEPTH) || (flush && acc_cnt[i] != '0))
          hold_d[i] = 1'b1;
      end
    end
  end

  // Stage: output register
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_count_d = out_count_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sum_q[gnt_idx];
      out_ch_d    = gnt_idx;
      out_count_d = cnt_q[gnt_idx];
      ptr_d       = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_count_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_count_q <= out_count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= sum_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_accum_top.sv
module tb_multi_channel_accum_top;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int SUM_W  = 10;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       in_valid = '0;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data = '0;
  logic                    flush = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [SUM_W-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic [CNT_W-1:0]        out_count;

  multi_channel_accum_top #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SUM_W-1:0] d;
    logic [CH_W-1:0]  c;
    logic [CNT_W-1:0] n;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int c, input int n);
    res_t r;
    r.d = SUM_W'(d);
    r.c = CH_W'(c);
    r.n = CNT_W'(n);
    exp_q.push_back(r);
  endtask

  // Drive one cycle of samples: valid mask plus the same value layout per lane
  task automatic drive(input logic [NUM_CH-1:0] vmask, input logic [NUM_CH*WIDTH-1:0] data);
    in_valid = vmask;
    in_data  = data;
    tick();
    in_valid = '0;
  endtask

  task automatic send(input int ch, input int val);
    logic [NUM_CH*WIDTH-1:0] d;
    d = '0;
    d[ch*WIDTH +: WIDTH] = WIDTH'(val);
    drive(NUM_CH'(1) << ch, d);
  endtask

  // Scoreboard: every handshake pops the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_ch), 32'hFFFF_FFFF);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_data",  32'(out_data),  32'(e.d));
        chk("sb_ch",    32'(out_ch),    32'(e.c));
        chk("sb_count", 32'(out_count), 32'(e.n));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH*WIDTH-1:0] d;
    logic [SUM_W-1:0] h_data;
    logic [CH_W-1:0]  h_ch;
    logic [CNT_W-1:0] h_cnt;

    // 1. Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = NUM_CH'($urandom);
      in_data   = {$urandom, $urandom};
      flush     = 1'(
$urandom);
      out_ready = 1'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = '0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_ch",    32'(out_ch),    0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_in_ready",  32'(in_ready),  32'hF);

    // 2. Single group on ch0, latency and in_ready dip
    push(100, 0, 4);
    send(0, 10); send(0, 20); send(0, 30); send(0, 40);
    chk("lat_in_ready0_low", 32'(in_ready[0]), 0);
    chk("lat_valid_early",   32'(out_valid),   0);
    tick();
    chk("lat_valid",      32'(out_valid), 1);
    chk("lat_data",       32'(out_data),  100);
    chk("lat_ch",         32'(out_ch),    0);
    chk("lat_count",      32'(out_count), 4);
    chk("lat_in_ready0",  32'(in_ready[0]), 1);
    tick();
    chk("lat_valid_drop", 32'(out_valid), 0);

    // 3. Width boundary on ch3
    push(1020, 3, 4);
    for (int i = 0; i < 4; i++) send(3, 255);
    tick();
    chk("wide_data", 32'(out_data), 1020);
    chk("wide_ch",   32'(out_ch),   3);
    tick(); tick();

    // 4. Contention, pointer at 3 -> order 0,1,2,3
    for (int i = 0; i < NUM_CH; i++) d[i*WIDTH +: WIDTH] = WIDTH'(10 * (i + 1));
    for (int i = 0; i < NUM_CH; i++) push(40 * (i + 1), i, 4);
    for (int s = 0; s < 4; s++) drive('1, d);
    tick();
    for (int k = 0; k < NUM_CH; k++) begin
      chk("rr0_valid", 32'(out_valid), 1);
      chk("rr0_ch",    32'(out_ch),    k);
      tick();
    end
    chk("rr0_drain", 32'(out_valid), 0);

    // pointer to 1 via a ch1 group, then order 2,3,0,1
    push(4, 1, 4);
    for (int s = 0; s < 4; s++) send(1, 1);
    tick(); tick();
    for (int k = 0; k < NUM_CH; k++) push(40 * (((k + 2) % 4) + 1), (k + 2) % 4, 4);
    for (int s = 0; s < 4; s++) drive('1, d);
    tick();
    for (int k = 0; k < NUM_CH; k++) begin
      chk("rr1_valid", 32'(out_valid), 1);
      chk("rr1_ch",    32'(out_ch),    (k + 2) % 4);
      tick();
    end
    chk("rr1_drain", 32'(out_valid), 0);

    // 5. Backpressure
    out_ready = 1'b0;
    push(10, 0, 4);
    push(26, 1, 4);
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    send(1, 5); send(1, 6); send(1, 7); send(1, 8);
    h_data = out_data; h_ch = out_ch; h_cnt = out_count;
    chk("bp_first_data", 32'(h_data), 10);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid",   32'(out_valid),   1);
      chk("bp_data",    32'(out_data),    32'(h_data));
      chk("bp_ch",      32'(out_ch),      32'(h_ch));
      chk("bp_count",   32'(out_count),   32'(h_cnt));
      chk("bp_ready1",  32'(in_ready[1]), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_second_ch",   32'(out_ch),      1);
    chk("bp_second_data", 32'(out_data),    26);
    chk("bp_ready1_back", 32'(in_ready[1]), 1);
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // 6. Flush: ch2 holds 5,6, ch1 empty
    push(11, 2, 2);
    send(2, 5); send(2, 6);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_in_ready", 32'(in_ready), 32'hB);
    tick();
    chk("fl_valid", 32'(out_valid), 1);
    chk("fl_data",  32'(out_data),  11);
    chk("fl_ch",    32'(out_ch),    2);
    chk("fl_count", 32'(out_count), 2);
    tick();
    chk("fl_single", 32'(out_valid), 0);

    // Reset discards ch0's partial group
    send(0, 3); send(0, 4);
    rst = 1'b1; tick(); rst = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rst_mid_quiet", 32'(out_valid), 0);
      tick();
    end
    // Flush on the same cycle as a lone accept closes a 1-sample group
    push(7, 0, 1);
    in_valid = 4'b0001; in_data = '0; in_data[7:0] = 8'd7; flush = 1'b1;
    tick();
    in_valid = '0; flush = 1'b0;
    tick();
    chk("fl_acc_data",  32'(out_data),  7);
    chk("fl_acc_count", 32'(out_count), 1);
    tick(); tick();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
